// File: rtl/wishbone_classic_arbiter_if.sv
// wishbone_classic_arbiter_if: controller-side and device-side Wishbone classic buses around the arbiter
interface wishbone_classic_arbiter_if #(
    parameter int N      = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N-1:0]          c_cyc_i, c_stb_i, c_we_i;
    logic [N*ADDR_W-1:0]   c_adr_i;
    logic [N*DATA_W-1:0]   c_dat_i;
    logic [N*DATA_W/8-1:0] c_sel_i;
    logic [N-1:0]          c_ack_o, c_err_o, c_rty_o;
    logic [DATA_W-1:0]     c_dat_o;
    logic                  d_cyc_o, d_stb_o, d_we_o;
    logic [ADDR_W-1:0]     d_adr_o;
    logic [DATA_W-1:0]     d_dat_o;
    logic [DATA_W/8-1:0]   d_sel_o;
    logic                  d_ack_i, d_err_i, d_rty_i;
    logic [DATA_W-1:0]     d_dat_i;
    logic [N-1:0]          gnt_o;

    modport slave (
        input  c_cyc_i, c_stb_i, c_we_i, c_adr_i, c_dat_i, c_sel_i,
        input  d_ack_i, d_err_i, d_rty_i, d_dat_i,
        output c_ack_o, c_err_o, c_rty_o, c_dat_o,
        output d_cyc_o, d_stb_o, d_we_o, d_adr_o, d_dat_o, d_sel_o, gnt_o
    );

    modport master (
        output c_cyc_i, c_stb_i, c_we_i, c_adr_i, c_dat_i, c_sel_i,
        output d_ack_i, d_err_i, d_rty_i, d_dat_i,
        input  c_ack_o, c_err_o, c_rty_o, c_dat_o,
        input  d_cyc_o, d_stb_o, d_we_o, d_adr_o, d_dat_o, d_sel_o, gnt_o
    );
endinterface

// File: rtl/wishbone_classic_arbiter.sv
// wishbone_classic_arbiter: round-robin sharing of one Wishbone classic device among N controllers.
// Define WB_ARB_TIMEOUT_EN to compile in the watchdog that aborts unanswered cycles.
module wishbone_classic_arbiter #(
    parameter int N              = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic clk_i,
    input logic rst_ni,
    wishbone_classic_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int SW = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        GRANT
`ifdef WB_ARB_TIMEOUT_EN
        , ABORT
`endif
    } state_t;

    state_t        state;
    logic [N-1:0]  gnt;
    logic [IW-1:0] idx, ptr, win;
    logic          own_cyc, tmo, act;

    // Descending scan so the requester closest to ptr (mod N) is the last to write win.
    always_comb begin
        win = ptr;
        for (int i = N - 1; i >= 0; i--)
            if (bus.c_cyc_i[(int'(ptr) + i) % N]) win = IW'((int'(ptr) + i) % N);
    end

    assign own_cyc = bus.c_cyc_i[idx];
    assign act     = state == GRANT && own_cyc && !tmo;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt;
    logic          rsp;
    assign rsp = bus.d_ack_i | bus.d_err_i | bus.d_rty_i;
    assign tmo = state == GRANT && own_cyc && cnt == TW'(TIMEOUT_CYCLES);
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt <= '0;
        else cnt <= (bus.d_stb_o && !rsp) ? cnt + 1'b1 : '0;
`else
    assign tmo = 1'b0;
`endif

    assign bus.gnt_o   = gnt;
    assign bus.d_cyc_o = act;
    assign bus.d_stb_o = act & bus.c_stb_i[idx];
    assign bus.d_we_o  = act & bus.c_we_i[idx];
    assign bus.d_adr_o = act ? bus.c_adr_i[int'(idx)*ADDR_W +: ADDR_W] : '0;
    assign bus.d_dat_o = act ? bus.c_dat_i[int'(idx)*DATA_W +: DATA_W] : '0;
    assign bus.d_sel_o = act ? bus.c_sel_i[int'(idx)*SW +: SW] : '0;
    assign bus.c_ack_o = {N{act & bus.d_ack_i}} & gnt;
    assign bus.c_err_o = ({N{act & bus.d_err_i}} | {N{tmo}}) & gnt;
    assign bus.c_rty_o = {N{act & bus.d_rty_i}} & gnt;
    assign bus.c_dat_o = bus.d_dat_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            gnt   <= '0;
            idx   <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: if (|bus.c_cyc_i) begin
                    state <= GRANT;
                    gnt   <= N'(1) << win;
                    idx   <= win;
                    ptr   <= (int'(win) == N - 1) ? '0 : win + 1'b1;
                end
                default: if (!own_cyc) begin
                    state <= IDLE;
                    gnt   <= '0;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (tmo) state <= ABORT;
`endif
            endcase
        end
    end
endmodule

// File: tb/tb_wishbone_classic_arbiter.sv
// tb_wishbone_classic_arbiter: table-driven scoreboard bench for a two-controller arbiter,
// with hand-written reset-in-cycle and watchdog sequences.
module tb_wishbone_classic_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    wishbone_classic_arbiter_if #(.N(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    wishbone_classic_arbiter #(
        .N(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  cyc, stb, we;
        logic          ack, err, rty;
        logic [N-1:0]  gnt;
        logic          dcyc;
        logic [N-1:0]  cack, cerr, crty;
        logic [DW-1:0] dat;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic [N-1:0] cyc, stb, we, input logic [2:0] rsp,
                                input logic [N-1:0] gnt, input logic dcyc,
                                input logic [N-1:0] cack, cerr, crty);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.we = we;
        {v.ack, v.err, v.rty} = rsp;
        v.gnt = gnt; v.dcyc = dcyc;
        v.cack = cack; v.cerr = cerr; v.crty = crty;
        v.dat = '0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        vec_t e;
        int k;
        e = sb.pop_front();
        k = e.gnt[1] ? 1 : 0;
        check("gnt", 32'(bus.gnt_o), 32'(e.gnt));
        check("d_cyc", 32'(bus.d_cyc_o), 32'(e.dcyc));
        check("d_stb", 32'(bus.d_stb_o), 32'(e.dcyc & e.stb[k]));
        check("d_we", 32'(bus.d_we_o), 32'(e.dcyc & e.we[k]));
        check("d_adr", bus.d_adr_o, e.dcyc ? 32'hA000_0000 + 32'(k) : 32'h0);
        check("d_dat", bus.d_dat_o, e.dcyc ? 32'hD000_0000 + 32'(k) : 32'h0);
        check("d_sel", 32'(bus.d_sel_o), e.dcyc ? (k == 1 ? 32'hC : 32'h3) : 32'h0);
        check("c_ack", 32'(bus.c_ack_o), 32'(e.cack));
        check("c_err", 32'(bus.c_err_o), 32'(e.cerr));
        check("c_rty", 32'(bus.c_rty_o), 32'(e.crty));
        check("c_dat", bus.c_dat_o, e.dat);
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        v.dat = $urandom;
        bus.c_cyc_i = v.cyc;
        bus.c_stb_i = v.stb;
        bus.c_we_i  = v.we;
        bus.d_ack_i = v.ack;
        bus.d_err_i = v.err;
        bus.d_rty_i = v.rty;
        bus.d_dat_i = v.dat;
        sb.push_back(v);
        @(negedge clk);
        compare();
    endtask

    initial begin
        bus.c_cyc_i = 2'b11;
        bus.c_stb_i = 2'b11;
        bus.c_we_i  = 2'b00;
        bus.c_adr_i = {32'hA000_0001, 32'hA000_0000};
        bus.c_dat_i = {32'hD000_0001, 32'hD000_0000};
        bus.c_sel_i = 8'hC3;
        bus.d_ack_i = 1'b1;
        bus.d_err_i = 1'b0;
        bus.d_rty_i = 1'b0;
        bus.d_dat_i = 32'h1234_5678;

        // single request, stray response, simultaneous requests, burst hold, handover
        tbl.push_back(mk(2'b01, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 2'b01, 3'b000, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 3'b000, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 3'b100, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 3'b100, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b10, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b10, 3'b100, 2'b10, 1'b1, 2'b10, 2'b00, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 3'b100, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 3'b010, 2'b01, 1'b1, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(2'b10, 2'b10, 2'b00, 3'b000, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 2'b00, 3'b001, 2'b10, 1'b1, 2'b00, 2'b00, 2'b10));
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 3'b000, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b01, 2'b01, 3'b100, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b10, 2'b00, 3'b000, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b01, 2'b01, 3'b100, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b01, 2'b00, 3'b100, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b11, 2'b01, 2'b01, 3'b100, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(2'b10, 2'b10, 2'b00, 3'b000, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b10, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b10, 2'b10, 2'b10, 3'b100, 2'b10, 1'b1, 2'b10, 2'b00, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 3'b000, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));

        #12;
        check("rst_gnt", 32'(bus.gnt_o), 32'h0);
        check("rst_d_cyc", 32'(bus.d_cyc_o), 32'h0);
        check("rst_d_stb", 32'(bus.d_stb_o), 32'h0);
        check("rst_d_adr", bus.d_adr_o, 32'h0);
        check("rst_c_ack", 32'(bus.c_ack_o), 32'h0);
        bus.c_cyc_i = 2'b00;
        bus.d_ack_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // reset in the middle of a granted cycle: pointer was 1, must restart at 0
        apply(mk(2'b01, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));
        apply(mk(2'b01, 2'b01, 2'b00, 3'b000, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00));
        #2;
        bus.d_ack_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_d_cyc", 32'(bus.d_cyc_o), 32'h0);
        check("midrst_gnt", 32'(bus.gnt_o), 32'h0);
        check("midrst_c_ack", 32'(bus.c_ack_o), 32'h0);
        check("midrst_d_sel", 32'(bus.d_sel_o), 32'h0);
        bus.c_cyc_i = 2'b00;
        bus.d_ack_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(2'b11, 2'b11, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));
        apply(mk(2'b11, 2'b11, 2'b00, 3'b000, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00));
        apply(mk(2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00));
        apply(mk(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));

        // unanswered cycle: aborted after 4 stalled cycles when the watchdog exists, held otherwise
        apply(mk(2'b01, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));
        for (int i = 0; i < 4; i++)
            apply(mk(2'b01, 2'b01, 2'b00, 3'b000, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00));
        apply(mk(2'b01, 2'b01, 2'b00, 3'b000, 2'b01, !WD, 2'b00, WD ? 2'b01 : 2'b00, 2'b00));
        apply(mk(2'b01, 2'b01, 2'b00, 3'b100, 2'b01, !WD, WD ? 2'b00 : 2'b01, 2'b00, 2'b00));
        apply(mk(2'b01, 2'b01, 2'b00, 3'b000, 2'b01, !WD, 2'b00, 2'b00, 2'b00));
        apply(mk(2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00));
        apply(mk(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
